mux_scan_reg: RTL and testbench



---
 rtl/mux_scan_reg.sv | 106 ++++++++++
 tb/tb_mux_scan_reg.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mux_scan_reg.sv
// Registered CH-channel, N-bit selector with manual select and auto-scan modes.
// In scan mode each channel drives y for DIV cycles; wrap pulses on return to channel 0.
module mux_scan_reg #(
   parameter int N   = 4,
   parameter int CH  = 3,
   parameter int DIV = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               en,
   input  logic                               mode,
   input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] s,
   input  logic [CH*N-1:0]                    d,
   output logic [N-1:0]                       y,
   output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ch,
   output logic                               valid,
   output logic                               wrap
);

   localparam int SW = (CH > 1) ? $clog2(CH) : 1;
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [SW:0]   CH_LIM   = (SW+1)'(CH);
   localparam logic [SW-1:0] LAST_CH  = SW'(CH - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    y_q, y_d;
   logic [SW-1:0]   ch_q, ch_d;
   logic            valid_q, valid_d;
   logic            wrap_q, wrap_d;
   logic [SW-1:0]   nch;
   logic            load;
   logic            s_in_range;

   logic [N-1:0]    chan [CH];

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_chan
         assign chan[gi] = d[gi*N +: N];
      end
   endgenerate

   assign s_in_range = ({1'b0, s} < CH_LIM);

   always_comb begin
      state_d = state_q;
      nch     = ch_q;
      load    = 1'b0;
      cnt_d   = '0;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      if (!en) begin
         state_d = IDLE;
      end else if (!mode) begin
         state_d = MAN;
         if (s_in_range) begin
            nch     = s;
            load    = 1'b1;
            valid_d = 1'b1;
         end
      end else begin
         // Scan entry keeps the current channel and starts a fresh dwell.
         state_d = SCAN;
         load    = 1'b1;
         valid_d = 1'b1;
         if (state_q == SCAN) begin
            if (cnt_q == CNT_MAX) begin
               nch    = (ch_q == LAST_CH) ? '0 : ch_q + SW'(1);
               wrap_d = (ch_q == LAST_CH);
            end else begin
               cnt_d  = cnt_q + CW'(1);
            end
         end
      end
      y_d  = load ? chan[nch] : y_q;
      ch_d = load ? nch : ch_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         y_q     <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign y     = y_q;
   assign ch    = ch_q;
   assign valid = valid_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: directed plan steps plus random traffic against a
// dwell-time model that derives the scan channel from elapsed cycles since entry.
module tb_mux_scan_reg;

   localparam int N   = 4;
   localparam int CH  = 3;
   localparam int DIV = 4;
   localparam int SW  = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b0;
   logic            mode = 1'b0;
   logic [SW-1:0]   s = '0;
   logic [CH*N-1:0] d = '0;
   logic [N-1:0]    y;
   logic [SW-1:0]   ch;
   logic            valid;
   logic            wrap;

   int checks = 0;
   int failures = 0;

   // Reference model state
   int       m_ch, m_base, m_t;
   logic [N-1:0] m_y;
   logic     m_valid, m_wrap, m_scan;

   mux_scan_reg #(.N(N), .CH(CH), .DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .d(d),
      .y(y), .ch(ch), .valid(valid), .wrap(wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] dch(input int i);
      return d[i*N +: N];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ch = 0; m_y = '0; m_valid = 1'b0; m_wrap = 1'b0; m_scan = 1'b0;
      m_base = 0; m_t = 0;
   endtask

   task automatic model_step();
      if (!en) begin
         m_valid = 1'b0; m_wrap = 1'b0; m_scan = 1'b0;
      end else if (!mode) begin
         m_scan = 1'b0; m_wrap = 1'b0;
         if (int'(s) < CH) begin
            m_ch = int'(s); m_y = dch(m_ch); m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
      end else begin
         if (!m_scan) begin
            m_scan = 1'b1; m_base = m_ch; m_t = 0; m_wrap = 1'b0;
         end else begin
            m_t++;
            m_wrap = (m_t % DIV == 0) && (((m_base + m_t / DIV) % CH) == 0);
         end
         m_ch = (m_base + m_t / DIV) % CH;
         m_y = dch(m_ch);
         m_valid = 1'b1;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".y"},     32'(y),     32'(m_y));
      check({tag, ".ch"},    32'(ch),    32'(m_ch));
      check({tag, ".valid"}, 32'(valid), 32'(m_valid));
      check({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      compare_all(tag);
   endtask

   // Asserts reset between edges and checks outputs clear without a clock edge.
   task automatic reset_pulse(input string tag);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      compare_all(tag);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("por");
      rst_n = 1'b1;

      // Async reset while scanning
      d = 12'hCBA; en = 1'b1; mode = 1'b1;
      tick("t1_run"); tick("t1_run");
      reset_pulse("t1_rst");
      check("t1_y0", 32'(y), 32'h0);

      // Manual select
      mode = 1'b0;
      s = 2'd1; tick("t2_s1"); check("t2_yB", 32'(y), 32'hB);
      s = 2'd2; tick("t2_s2"); check("t2_yC", 32'(y), 32'hC);
      s = 2'd0; tick("t2_s0"); check("t2_yA", 32'(y), 32'hA);

      // Out-of-range select holds y/ch and drops valid
      s = 2'd1; tick("t3_s1");
      s = 2'd3; tick("t3_s3");
      check("t3_hold_y", 32'(y), 32'hB);
      check("t3_hold_v", 32'(valid), 32'h0);
      s = 2'd0; tick("t3_s0"); check("t3_yA", 32'(y), 32'hA);

      // Scan from ch=0, data change mid-dwell of ch=1
      mode = 1'b1;
      for (int i = 0; i < 6; i++) tick("t4_scan");
      check("t4_ch1", 32'(ch), 32'h1);
      d = 12'hC5A; tick("t4_dchg"); check("t4_y5", 32'(y), 32'h5);
      d = 12'hCBA;

      // Enable drop for 3 cycles at ch=1, cnt=2
      en = 1'b0;
      for (int i = 0; i < 3; i++) tick("t5_off");
      check("t5_frz_ch", 32'(ch), 32'h1);
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick("t5_dwell");
         check("t5_ch1", 32'(ch), 32'h1);
      end
      tick("t5_adv"); check("t5_ch2", 32'(ch), 32'h2);
      for (int i = 0; i < 12; i++) tick("t4_wrap");

      // Reset mid-scan at ch=2, cnt=2 (bounded search)
      begin
         int guard = 0;
         while (!(m_ch == 2 && m_t % DIV == 2) && guard < 40) begin
            tick("t6_seek"); guard++;
         end
         check("t6_found", 32'(guard < 40), 32'h1);
      end
      reset_pulse("t6_rst");
      for (int i = 0; i < 16; i++) tick("t6_resume");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         d    = CH*N'($urandom);
         en   = ($urandom_range(0, 9) != 0);
         mode = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) s = SW'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) reset_pulse("rnd_rst");
         else tick("rnd");
         if (mode && en && $urandom_range(0, 1) == 0) begin
            for (int k = 0; k < DIV * CH; k++) tick("rnd_scan");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
